// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: writeback-stage bus between the pipeline/bench (master) and the register file (slave)
// Carries the instruction fields into writeback and the decode, status and debug-read results back out.
interface writeback_regfile_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
);
  logic             wb_valid;
  logic [3:0]       icode;
  logic [3:0]       rA;
  logic [3:0]       rB;
  logic             cnd;
  logic [2:0]       stat;
  logic [WIDTH-1:0] valE;
  logic [WIDTH-1:0] valM;
  logic [3:0]       dbg_sel;
  logic [WIDTH-1:0] dbg_val;
  logic [3:0]       dstE;
  logic [3:0]       dstM;
  logic             halted;
  logic [CNT_W-1:0] retired;
  modport master (
    output wb_valid, icode, rA, rB, cnd, stat, valE, valM, dbg_sel,
    input  dbg_val, dstE, dstM, halted, retired
  );
  modport slave (
    input  wb_valid, icode, rA, rB, cnd, stat, valE, valM, dbg_sel,
    output dbg_val, dstE, dstM, halted, retired
  );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 SEQ writeback stage owning the 15-entry register file
// Ports: clk (rising-edge state updates), reset_n (asynchronous active-low reset),
//   bus (slave): wb_valid/icode/rA/rB/cnd/stat/valE/valM in; dstE/dstM decode,
//   sticky halted flag, retired instruction count and dbg_sel -> dbg_val read port out.
module writeback_regfile #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset_n,
  writeback_regfile_if.slave bus
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [2:0] AOK   = 3'd1;
  logic [WIDTH-1:0] regs [15];
  logic             halted;
  logic [CNT_W-1:0] retired;
  always_comb begin
    bus.dstE = (bus.icode == 4'h2) ? (bus.cnd ? bus.rB : RNONE) :
               (bus.icode == 4'h3 || bus.icode == 4'h6) ? bus.rB :
               (bus.icode >= 4'h8 && bus.icode <= 4'hB) ? RSP : RNONE;
    bus.dstM = (bus.icode == 4'h5 || bus.icode == 4'hB) ? bus.rA : RNONE;
  end
  assign bus.dbg_val = (bus.dbg_sel == RNONE) ? '0 : regs[bus.dbg_sel];
  assign bus.halted  = halted;
  assign bus.retired = retired;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
      halted  <= 1'b0;
      retired <= '0;
    end else if (bus.wb_valid && !halted) begin
      if (bus.stat == AOK) begin
        if (bus.dstE != RNONE) regs[bus.dstE] <= bus.valE;
        // issued after the E write so valM wins when dstE == dstM (popq %rsp)
        if (bus.dstM != RNONE) regs[bus.dstM] <= bus.valM;
        retired <= retired + 1'b1;
      end else begin
        halted <= 1'b1;
      end
    end
  end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- SEQ writeback stage that owns the 15-entry Y86-64 register file.
- Decodes the destination registers dstE/dstM from icode/rA/rB/cnd and commits valE/valM on the clock edge.
- Latches a sticky halt on any non-AOK status.
- Counts retired instructions and exposes a combinational debug read port, so benches can check register contents directly.
- Write-side counterpart of the decode stage; decode reads the same storage through read ports added at integration.

Parameters:
- WIDTH, 64, register and data width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_valid  input  1  instruction present in writeback this cycle
- icode  input  4  instruction code (0 halt … B popq)
- rA  input  4  register specifier A (F = RNONE)
- rB  input  4  register specifier B (F = RNONE)
- cnd  input  1  condition result from execute (used by cmovXX)
- stat  input  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- valE  input  WIDTH  ALU result
- valM  input  WIDTH  memory read data
- dbg_sel  input  4  debug read register index
- dbg_val  output  WIDTH  contents of register dbg_sel; 0 when dbg_sel = F
- dstE  output  4  decoded E destination (combinational)
- dstM  output  4  decoded M destination (combinational)
- halted  output  1  sticky halt flag
- retired  output  CNT_W  count of committed AOK instructions

Behaviour:
- Reset (reset_n low, asynchronous): all 15 registers = 0, halted = 0, retired = 0.
- Reset mid-operation aborts any pending write; nothing commits on the edge while reset_n is low.
- dstE decode (combinational):
  - icode 2 → (cnd ? rB : F); icode 3 or 6 → rB.
  - icode 8, 9, A, B → 4 (%rsp).
  - All other icodes → F.
- dstM decode (combinational): icode 5 or B → rA; else F.
- Commit rule, rising edge with wb_valid = 1, stat = AOK, halted = 0:
  - Write valE to dstE if dstE != F.
  - Write valM to dstM if dstM != F.
  - retired += 1, wrapping modulo 2^CNT_W.
- dstE == dstM (e.g. popq %rsp): valM wins.
- Halt rule: edge with wb_valid = 1 and stat != AOK:
  - No register writes, retired unchanged, halted ← 1.
  - halted stays set until reset; all later edges ignored regardless of wb_valid/stat.
- wb_valid = 0: no state change (bubble).
- Index F is never storage; writes to F are dropped.
- dbg_val is combinational from current storage; a write becomes visible only after the edge (no write-through).
- Latency: one cycle from inputs to register update; dstE/dstM zero latency.

Test Plan:
- Reset then dbg_sel sweep 0..F → all dbg_val = 0, halted = 0, retired = 0.
- irmovq (icode 3, rB = 2, valE = 0x1234), AOK → after edge reg2 = 0x1234, retired = 1; dstM = F.
- cmovXX (icode 2, rB = 5, valE = 7) with cnd = 0 → reg5 unchanged, dstE = F, retired still increments. Repeat with cnd = 1 → reg5 = 7.
- popq %rsp (icode B, rA = 4, valE = 0x108, valM = 0xAA) → reg4 = 0xAA (M priority).
- Second popq case (icode B, rA = 3, valE = 0x110, valM = 0x55) → reg4 = 0x110, reg3 = 0x55 in the same edge.
- Halt: stat = 2 with icode 6, rB = 1, valE = 9 → reg1 unchanged, halted = 1. A following AOK irmovq to reg1 is ignored. Assert reset_n low mid-cycle → halted and all registers clear immediately, without waiting for a clock edge.
- Bubble and wrap:
  - wb_valid = 0 with icode 3 → no change.
  - With CNT_W = 4, 16 committed instructions → retired wraps to 0.
